// File: rtl/operand_sequencer.sv
// operand_sequencer: button-driven operand entry for a 4-bit adder.
// A push button is synchronized, optionally debounced, and edge-detected
// into a one-cycle press. Each press walks LOAD_A -> LOAD_B -> SHOW, and
// presses in SHOW chain the sum back into operand A (accumulator).
// Build option: define OPSEQ_DEBOUNCE_EN to include the debounce counter;
// without it the synchronized button level is used directly.
module operand_sequencer #(
  parameter int DB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_n,
  input  logic [3:0] sw,
  input  logic       clr,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [3:0] sum,
  output logic       cout,
  output logic [1:0] state,
  output logic       valid
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    SHOW   = 2'b10,
    UNUSED = 2'b11
  } state_t;

  state_t r_state;
  logic   r_sync1;
  logic   r_sync2;
  logic   r_db_prev;
  logic   r_press;
  logic   w_db;

  // Two-flop synchronizer for the asynchronous button; idles high (released).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef OPSEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          r_db;
  logic [CW-1:0] r_cnt;

  // Debounce: the level follows the sample only after DB_CYCLES
  // consecutive disagreeing cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_db  <= 1'b1;
      r_cnt <= '0;
    end else if (r_sync2 == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == DB_LAST) begin
      r_db  <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_db = r_db;
`else
  // Without debouncing the synchronized level is taken as clean.
  logic w_unused_db_cycles;
  assign w_unused_db_cycles = (DB_CYCLES > 0);
  assign w_db = r_sync2;
`endif

  // Falling-edge detect on the debounced level gives a one-cycle press pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_db_prev <= 1'b1;
      r_press   <= 1'b0;
    end else begin
      r_db_prev <= w_db;
      r_press   <= r_db_prev & ~w_db;
    end
  end

  // Operand FSM with registered outputs; clr has priority over a press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= LOAD_A;
      op_a    <= 4'd0;
      op_b    <= 4'd0;
      sum     <= 4'd0;
      cout    <= 1'b0;
      valid   <= 1'b0;
    end else if (clr) begin
      r_state <= LOAD_A;
      op_a    <= 4'd0;
      op_b    <= 4'd0;
      sum     <= 4'd0;
      cout    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (r_press) begin
            op_a    <= sw;
            r_state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (r_press) begin
            op_b          <= sw;
            {cout, sum}   <= {1'b0, op_a} + {1'b0, sw};
            r_state       <= SHOW;
            valid         <= 1'b1;
          end
        end
        SHOW: begin
          if (r_press) begin
            op_a    <= sum;
            op_b    <= 4'd0;
            cout    <= 1'b0;
            r_state <= LOAD_B;
            valid   <= 1'b0;
          end
        end
        default: begin
          r_state <= LOAD_A;
          valid   <= 1'b0;
        end
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer. Expected output snapshots
// {op_a, op_b, sum, cout, state, valid} are queued with the cycle at which
// they are due; a monitor compares them and flags any output change that
// occurs when nothing is due.
module tb_operand_sequencer;

  localparam int DB = 4;
`ifdef OPSEQ_DEBOUNCE_EN
  localparam int LAT = DB + 4;
`else
  localparam int LAT = 4;
`endif
  localparam int W = 16;

  logic       clk;
  logic       resetn;
  logic       key_n;
  logic [3:0] sw;
  logic       clr;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] sum;
  logic       cout;
  logic [1:0] state;
  logic       valid;

  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           cyc;
  int           errors;
  int           checks;
  logic         mon_en;
  logic [W-1:0] prev_snap;

  operand_sequencer #(.DB_CYCLES(DB)) dut (
    .clk    (clk),
    .resetn (resetn),
    .key_n  (key_n),
    .sw     (sw),
    .clr    (clr),
    .op_a   (op_a),
    .op_b   (op_b),
    .sum    (sum),
    .cout   (cout),
    .state  (state),
    .valid  (valid)
  );

  // Clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] snap(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] s, input logic c,
                                        input logic [1:0] st, input logic v);
    return {a, b, s, c, st, v};
  endfunction

  // Monitor: compare due expectations, otherwise outputs must hold still
  always @(negedge clk) begin
    logic [W-1:0] cur;
    cur = {op_a, op_b, sum, cout, state, valid};
    if (mon_en) begin
      while (due_q.size() > 0 && due_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_expect cyc=%0d due=%0d exp=%h", cyc, due_q[0], exp_q[0]);
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        checks++;
        if (cur !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d got a=%h b=%h s=%h c=%b st=%b v=%b exp a=%h b=%h s=%h c=%b st=%b v=%b",
                   cyc, cur[15:12], cur[11:8], cur[7:4], cur[3], cur[2:1], cur[0],
                   e[15:12], e[11:8], e[7:4], e[3], e[2:1], e[0]);
        end
      end else begin
        checks++;
        if (cur !== prev_snap) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%h exp=%h", cyc, cur, prev_snap);
        end
      end
      prev_snap = cur;
    end
  end

  // Driver tasks
  task automatic expect_at(input int due, input logic [W-1:0] e);
    due_q.push_back(due);
    exp_q.push_back(e);
  endtask

  task automatic do_press(input logic [3:0] v, input logic [W-1:0] e);
    @(negedge clk);
    sw    = v;
    key_n = 1'b0;
    expect_at(cyc + LAT, e);
    repeat (LAT + 2) @(negedge clk);
    key_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    expect_at(cyc + 1, '0);
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Press whose consuming edge also sees clr: the press must be discarded
  task automatic clr_with_press(input logic [3:0] v);
    @(negedge clk);
    sw    = v;
    key_n = 1'b0;
    expect_at(cyc + LAT, '0);
    repeat (LAT - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    key_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic bounce(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_n = 1'b0;
      repeat (DB - 1) @(negedge clk);
      key_n = 1'b1;
      repeat (DB + 3) @(negedge clk);
    end
  endtask

  // Watchdog
  initial begin
    repeat (5000) @(posedge clk);
    errors++;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Main sequence
  initial begin
    errors    = 0;
    checks    = 0;
    mon_en    = 1'b0;
    prev_snap = '0;
    resetn    = 1'b0;
    key_n     = 1'b1;
    sw        = 4'd0;
    clr       = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;
    expect_at(cyc + 1, '0);
    repeat (2) @(negedge clk);

    // 3 then 4
    do_press(4'd3, snap(4'd3, 4'd0, 4'd0, 1'b0, 2'b01, 1'b0));
    do_press(4'd4, snap(4'd3, 4'd4, 4'd7, 1'b0, 2'b10, 1'b1));
    do_clear();

    // 9 + 8 overflows, then accumulate chain
    do_press(4'd9, snap(4'd9, 4'd0, 4'd0, 1'b0, 2'b01, 1'b0));
    do_press(4'd8, snap(4'd9, 4'd8, 4'd1, 1'b1, 2'b10, 1'b1));
    do_press(4'd5, snap(4'd1, 4'd0, 4'd1, 1'b0, 2'b01, 1'b0));
    do_press(4'd5, snap(4'd1, 4'd5, 4'd6, 1'b0, 2'b10, 1'b1));
    do_press(4'hF, snap(4'd6, 4'd0, 4'd6, 1'b0, 2'b01, 1'b0));
    do_press(4'hF, snap(4'd6, 4'hF, 4'd5, 1'b1, 2'b10, 1'b1));
    do_clear();

`ifdef OPSEQ_DEBOUNCE_EN
    // Short bounces must not register while the monitor watches for changes
    sw = 4'd2;
    bounce(3);
`endif
    do_press(4'd2, snap(4'd2, 4'd0, 4'd0, 1'b0, 2'b01, 1'b0));

    // clr coincident with the press in LOAD_B
    clr_with_press(4'd7);

    // Reset mid-debounce with the button held
    do_press(4'd1, snap(4'd1, 4'd0, 4'd0, 1'b0, 2'b01, 1'b0));
    @(negedge clk);
    sw    = 4'hA;
    key_n = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    resetn = 1'b0;
    due_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    prev_snap = '0;
    resetn    = 1'b1;
    expect_at(cyc + 1, '0);
    expect_at(cyc + LAT, snap(4'hA, 4'd0, 4'd0, 1'b0, 2'b01, 1'b0));
    mon_en = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    key_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);

    // Drain any outstanding expectations
    for (int i = 0; i < 50 && due_q.size() > 0; i++) @(negedge clk);
    if (due_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got=%0d pending exp=0", due_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
